// File: rtl/function_unit_pkg.sv
// Shared definitions for the function unit: opcodes, FSM states and the
// bit positions of the {N, Z, C, V} flag word.
// The MUL state only exists when FUNCTION_UNIT_MUL_EN is defined.
package function_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
`ifdef FUNCTION_UNIT_MUL_EN
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
`else
    S_IDLE = 2'd0,
    S_DONE = 2'd2
`endif
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Assemble the flag word from its individual bits.
  function automatic logic [3:0] packFlags(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/fu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per step.
// o_product is the accumulator value *after* the current step, so the
// owner can capture the final product on the same edge as the last step.
module fu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product  = w_acc_next;
  assign o_last     = (r_count == CW'(WIDTH - 1));

  // Load the operands, then per step add the shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= o_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/function_unit.sv
// Function unit: single-cycle ALU ops plus an optional multi-cycle multiply.
// Result, flags and write strobe feed the register file directly.
// Define FUNCTION_UNIT_MUL_EN to build the shift-add multiplier; without it,
// op 7 completes in one cycle with a zero result.
module function_unit
  import function_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [3:0]       flags
);

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [AW-1:0]    r_wr_addr;

  op_e              w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [3:0]       w_alu_flags;

  assign w_op   = op_e'(op);
  assign w_sum  = {1'b0, val_a} + {1'b0, val_b};
  assign w_diff = {1'b0, val_a} - {1'b0, val_b};

  // Single-cycle datapath working on the live operands; only sampled on the capture edge.
  always_comb begin
    w_alu_result = '0;
    w_alu_c      = 1'b0;
    w_alu_v      = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_result = w_sum[WIDTH-1:0];
        w_alu_c      = w_sum[WIDTH];
        w_alu_v      = (val_a[WIDTH-1] == val_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != val_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_result = w_diff[WIDTH-1:0];
        w_alu_c      = ~w_diff[WIDTH];
        w_alu_v      = (val_a[WIDTH-1] != val_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != val_a[WIDTH-1]);
      end
      OP_AND: w_alu_result = val_a & val_b;
      OP_OR:  w_alu_result = val_a | val_b;
      OP_XOR: w_alu_result = val_a ^ val_b;
      OP_NOT: w_alu_result = ~val_a;
      OP_SHL: begin
        w_alu_result = {val_a[WIDTH-2:0], 1'b0};
        w_alu_c      = val_a[WIDTH-1];
      end
      default: w_alu_result = '0;
    endcase
  end

  assign w_alu_flags = packFlags(w_alu_result[WIDTH-1], (w_alu_result == '0),
                                 w_alu_c, w_alu_v);

`ifdef FUNCTION_UNIT_MUL_EN
  logic               w_mul_load;
  logic               w_mul_step;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0]   w_mul_low;
  logic [3:0]         w_mul_flags;

  assign w_mul_load  = (r_state == S_IDLE) && start && (w_op == OP_MUL);
  assign w_mul_step  = (r_state == S_MUL);
  assign w_mul_low   = w_mul_product[WIDTH-1:0];
  assign w_mul_flags = packFlags(w_mul_low[WIDTH-1], (w_mul_low == '0),
                                 |w_mul_product[2*WIDTH-1:WIDTH], 1'b0);

  fu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_a       (val_a),
    .i_b       (val_b),
    .o_product (w_mul_product),
    .o_last    (w_mul_last)
  );
`endif

  // Control FSM; result/flags only change on the edge that enters DONE, and done lasts one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
      r_wr_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wr_addr <= dest;
            r_busy    <= 1'b1;
`ifdef FUNCTION_UNIT_MUL_EN
            if (w_op == OP_MUL) begin
              r_state <= S_MUL;
            end else begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_alu_result;
              r_flags  <= w_alu_flags;
            end
`else
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_alu_result;
            r_flags  <= w_alu_flags;
`endif
          end
        end
`ifdef FUNCTION_UNIT_MUL_EN
        S_MUL: begin
          if (w_mul_last) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_mul_low;
            r_flags  <= w_mul_flags;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign wr_en   = r_done;
  assign result  = r_result;
  assign flags   = r_flags;
  assign wr_addr = r_wr_addr;

endmodule

// File: doc/function_unit.md
FUNCTION_UNIT -- requirements
Module: function_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (equals register file data width).
REQ-002 SHALL have parameter AW, default 3, destination register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 MUL.
REQ-007 SHALL have port val_a  input  WIDTH  operand A from register file port A.
REQ-008 SHALL have port val_b  input  WIDTH  operand B from register file port B (register or constant).
REQ-009 SHALL have port dest  input  AW  destination register address.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-012 SHALL have port result  output  WIDTH  registered result, drives register file d_in.
REQ-013 SHALL have port wr_en  output  1  register file load strobe; equals done.
REQ-014 SHALL have port wr_addr  output  AW  captured dest, valid with wr_en.
REQ-015 SHALL have port flags  output  4  {N, Z, C, V}, registered with result.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DONE.
REQ-017 SHALL, in IDLE with start=1, capture op, val_a, val_b, dest on that edge; later operand changes have no effect.
REQ-018 SHALL, for op 0-6, go IDLE->DONE; done/wr_en high exactly 1 cycle after the capture edge.
REQ-019 SHALL, for MUL, go IDLE->MUL, run WIDTH shift-add iterations (one per cycle), then DONE; done high WIDTH+1 cycles after capture.
REQ-020 SHALL return DONE->IDLE unconditionally after one cycle; start in DONE is ignored.
REQ-021 SHALL drive busy=1 in MUL and DONE, 0 in IDLE; start while busy is ignored, no queuing.
REQ-022 SHALL update result/flags only on the DONE-entry edge; hold between operations.
REQ-023 SHALL compute ADD/SUB modulo 2^WIDTH; C = carry-out (ADD) or NOT borrow (SUB); V = signed overflow.
REQ-024 SHALL for SHL set C = val_a MSB; for logic ops C=0, V=0.
REQ-025 SHALL for MUL output low WIDTH bits of the 2*WIDTH product; C=1 iff high half nonzero; V=0.
REQ-026 SHALL set Z = (result==0), N = result MSB, for every op.

Reset
REQ-027 SHALL on reset=0 immediately force IDLE, busy=0, done=0, wr_en=0, result=0, flags=0, wr_addr=0, iteration counter=0.
REQ-028 SHALL abort an in-progress MUL on reset with no wr_en pulse; first start after release behaves as from power-up.

Configuration
REQ-029 SHALL gate the multiplier with macro FUNCTION_UNIT_MUL_EN.
REQ-030 SHALL, with FUNCTION_UNIT_MUL_EN defined, implement MUL per REQ-019/025.
REQ-031 SHALL, without it, omit MUL state and datapath; op 7 completes in 1 cycle with result=0, flags={0,1,0,0}.

Structure
REQ-032 SHALL place opcode enum, FSM state enum, flag bit indices in shared package function_unit_pkg.
REQ-033 SHALL implement the shift-add multiplier as sub-module fu_mul_seq (load, step, product, last-iteration).

Verification
REQ-034 SHALL verify ADD 8'hAA+8'h01, dest=3 -> result 8'hAB, wr_addr=3, wr_en 1 cycle after start, flags 4'b1000.
REQ-035 SHALL verify ADD 8'hFF+8'h01 -> result 8'h00, Z=1, C=1; SUB 8'h80-8'h01 -> 8'h7F, V=1, C=1.
REQ-036 SHALL verify MUL 8'h0D*8'h0B -> 8'h8F, C=0, done 9 cycles after start; MUL 8'h10*8'h10 -> 8'h00, Z=1, C=1.
REQ-037 SHALL verify start pulsed during MUL cycle 4 with op=ADD -> ignored, single done, MUL result.
REQ-038 SHALL verify reset asserted mid-MUL (not on a clock edge) -> outputs zero immediately, no wr_en, next ADD correct.
REQ-039 SHALL verify without FUNCTION_UNIT_MUL_EN: op 7 -> result 8'h00, Z=1, done after 1 cycle.
